mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ADDR_W, default 11, data-memory word-address width.
REQ-002 Parameter SP_INIT, default {ADDR_W{1'b1}}, stack-pointer reset value (top of memory).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 valid_in  in  1  EX/MEM holds a live instruction.
REQ-006 op  in  3  0 NOP, 1 LDD, 2 STD, 3 PUSH, 4 POP, 5 INT, 6 RET, 7 RTI.
REQ-007 ea  in  16  effective address for LDD/STD; low ADDR_W bits used.
REQ-008 store_data  in  16  STD/PUSH write data.
REQ-009 pc_in  in  16  return PC pushed by INT.
REQ-010 flags_in  in  4  flags pushed by INT (second word, zero-extended).
REQ-011 wb_sel_in  in  2; alu_value_in, imm_in, in_port_in  in  16 each; rd_in  in  3; reg_we_in, outport_en_in  in  1  write-back controls passed through.
REQ-012 mem_addr  out  ADDR_W; mem_wdata  out  16; mem_we  out  1; mem_rdata  in  16  (combinational read, write on rising edge).
REQ-013 stall  out  1  upstream must hold EX/MEM this cycle.
REQ-014 pc_load  out  1; pc_out  out  16  PC redirect from RET/RTI.
REQ-015 flags_load  out  1; flags_out  out  4  flag restore from RTI.
REQ-016 sel, alu_value, immediate_value, mem_data, input_port_val, rd, reg_we, outport_enable  out  registered MEM/WB fields driving the write-back stage.

Function
REQ-017 Stack convention: SP addresses next free word; push writes mem[SP] then SP-1; pop reads mem[SP+1] then SP+1; SP arithmetic modulo 2^ADDR_W (0 underflows to SP_INIT, SP_INIT+1 wraps to 0), no error flag.
REQ-018 FSM states IDLE, SECOND; IDLE->SECOND on valid INT or RTI; SECOND->IDLE unconditionally; all other ops stay in IDLE.
REQ-019 LDD: mem_addr=ea, mem_we=0; STD: mem_addr=ea, mem_we=1, mem_wdata=store_data; one cycle each.
REQ-020 PUSH: write store_data at SP, SP decrements; POP: read SP+1, SP increments; one cycle each.
REQ-021 RET: read SP+1, SP increments, pc_load=1 and pc_out=mem_rdata same cycle.
REQ-022 INT: IDLE cycle writes pc_in at SP; SECOND cycle writes {12'b0,flags_in} at SP-1; SP decrements by 2 total.
REQ-023 RTI: IDLE cycle pops flags (flags_load=1, flags_out=mem_rdata[3:0]); SECOND cycle pops PC (pc_load=1).
REQ-024 stall=1 exactly in the IDLE cycle of INT/RTI; 0 otherwise.
REQ-025 pc_load, flags_load, mem_we are combinational single-cycle pulses; 0 when valid_in=0 or op=NOP.
REQ-026 MEM/WB register loads every non-stall cycle: mem_data<=mem_rdata, other fields <= their *_in; latency 1 cycle.
REQ-027 During stall, or valid_in=0, MEM/WB loads reg_we=0 and outport_enable=0 (bubble); other fields don't-care.
REQ-028 sel values: 00 immediate, 01 ALU, 10 memory, 11 input port; passed unchanged.

Reset
REQ-029 rst=0 at a rising edge: state=IDLE, SP=SP_INIT, all MEM/WB fields=0; reset mid-INT/RTI abandons the second word.
REQ-030 While rst=0: stall, mem_we, pc_load, flags_load = 0.

Structure
REQ-031 Opcode encodings, FSM state encoding and sel encodings live in shared package cpu_pkg.
REQ-032 MEM/WB register is one sub-module mem_wb_reg; FSM, SP and memory muxing stay in mem_stage.

Verification
REQ-033 Reset, PUSH 16'hABCD -> mem[7FF]=ABCD, SP=7FE; POP rd=3 -> next cycle mem_data=ABCD, reg_we=1, SP=7FF.
REQ-034 STD ea=0x0010 data=0x1234, then LDD ea=0x0010 -> mem_data=0x1234 one cycle after LDD, sel=10.
REQ-035 INT pc_in=0x0040 flags=4'b1010 -> stall 1 cycle, mem[7FF]=0040, mem[7FE]=000A, SP=7FD; RTI -> flags_load with 4'b1010, then pc_load with 0x0040, SP=7FF.
REQ-036 POP at SP=7FF -> reads mem[000], SP=000 (wrap).
REQ-037 rst=0 asserted during INT SECOND cycle -> next cycle state IDLE, SP=7FF, reg_we=0, no write to mem[7FE].
REQ-038 valid_in=0 with op=STD -> mem_we=0, MEM/WB reg_we=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU pipeline: opcodes, MEM-stage FSM states,
// write-back source selects and common widths.
package cpu_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned FLAGS_W = 4;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LDD  = 3'd1,
        OP_STD  = 3'd2,
        OP_PUSH = 3'd3,
        OP_POP  = 3'd4,
        OP_INT  = 3'd5,
        OP_RET  = 3'd6,
        OP_RTI  = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SEL_IMM    = 2'b00,
        SEL_ALU    = 2'b01,
        SEL_MEM    = 2'b10,
        SEL_INPORT = 2'b11
    } sel_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. Loads every cycle; a bubble clears the two
// architectural side-effect enables so the write-back stage does nothing.
module mem_wb_reg
    import cpu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_bubble,
    input  logic [1:0]        i_sel,
    input  logic [DATA_W-1:0] i_alu_value,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic [DATA_W-1:0] i_in_port,
    input  logic [2:0]        i_rd,
    input  logic              i_reg_we,
    input  logic              i_outport_en,
    output logic [1:0]        o_sel,
    output logic [DATA_W-1:0] o_alu_value,
    output logic [DATA_W-1:0] o_imm,
    output logic [DATA_W-1:0] o_mem_data,
    output logic [DATA_W-1:0] o_in_port,
    output logic [2:0]        o_rd,
    output logic              o_reg_we,
    output logic              o_outport_en
);

    // Capture write-back fields; bubble forces the enables low.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_sel        <= '0;
            o_alu_value  <= '0;
            o_imm        <= '0;
            o_mem_data   <= '0;
            o_in_port    <= '0;
            o_rd         <= '0;
            o_reg_we     <= 1'b0;
            o_outport_en <= 1'b0;
        end else begin
            o_sel        <= i_sel;
            o_alu_value  <= i_alu_value;
            o_imm        <= i_imm;
            o_mem_data   <= i_mem_data;
            o_in_port    <= i_in_port;
            o_rd         <= i_rd;
            o_reg_we     <= i_bubble ? 1'b0 : i_reg_we;
            o_outport_en <= i_bubble ? 1'b0 : i_outport_en;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory access, stack pointer, two-word INT/RTI
// sequencing and the MEM/WB register feeding write-back.
module mem_stage
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 11,
    parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [2:0]        op,
    input  logic [15:0]       ea,
    input  logic [15:0]       store_data,
    input  logic [15:0]       pc_in,
    input  logic [3:0]        flags_in,
    input  logic [1:0]        wb_sel_in,
    input  logic [15:0]       alu_value_in,
    input  logic [15:0]       imm_in,
    input  logic [15:0]       in_port_in,
    input  logic [2:0]        rd_in,
    input  logic              reg_we_in,
    input  logic              outport_en_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    input  logic [15:0]       mem_rdata,
    output logic              stall,
    output logic              pc_load,
    output logic [15:0]       pc_out,
    output logic              flags_load,
    output logic [3:0]        flags_out,
    output logic [1:0]        sel,
    output logic [15:0]       alu_value,
    output logic [15:0]       immediate_value,
    output logic [15:0]       mem_data,
    output logic [15:0]       input_port_val,
    output logic [2:0]        rd,
    output logic              reg_we,
    output logic              outport_enable
);

    localparam logic [ADDR_W-1:0] SP_ONE = 1;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_sp;
    logic [ADDR_W-1:0] w_sp_nxt;
    logic              r_sec_rti;
    logic              w_sec_rti_nxt;
    logic [ADDR_W-1:0] w_sp_inc;
    logic [ADDR_W-1:0] w_sp_dec;
    op_e               w_op;
    logic              w_bubble;
    logic              w_unused_ea;

    assign w_op        = op_e'(op);
    assign w_sp_inc    = r_sp + SP_ONE;
    assign w_sp_dec    = r_sp - SP_ONE;
    assign w_bubble    = stall | ~valid_in;
    assign w_unused_ea = ^ea[15:ADDR_W];

    // State, stack pointer and second-word kind registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_sp      <= SP_INIT;
            r_sec_rti <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sp      <= w_sp_nxt;
            r_sec_rti <= w_sec_rti_nxt;
        end
    end

    // Next-state, SP update and memory/redirect controls.
    // SP moves by one on each INT/RTI word, so the second word always
    // lands on the already-updated SP instead of needing an SP-1/SP+2 path.
    always_comb begin
        w_state_nxt   = ST_IDLE;
        w_sp_nxt      = r_sp;
        w_sec_rti_nxt = r_sec_rti;
        mem_addr      = ea[ADDR_W-1:0];
        mem_wdata     = store_data;
        mem_we        = 1'b0;
        stall         = 1'b0;
        pc_load       = 1'b0;
        pc_out        = mem_rdata;
        flags_load    = 1'b0;
        flags_out     = mem_rdata[FLAGS_W-1:0];
        if (!rst) begin
            w_state_nxt = ST_IDLE;
        end else if (r_state == ST_SECOND) begin
            if (r_sec_rti) begin
                mem_addr = w_sp_inc;
                pc_load  = 1'b1;
                w_sp_nxt = w_sp_inc;
            end else begin
                mem_addr  = r_sp;
                mem_wdata = {{(DATA_W-FLAGS_W){1'b0}}, flags_in};
                mem_we    = 1'b1;
                w_sp_nxt  = w_sp_dec;
            end
        end else if (valid_in) begin
            case (w_op)
                OP_STD: begin
                    mem_we = 1'b1;
                end
                OP_PUSH: begin
                    mem_addr = r_sp;
                    mem_we   = 1'b1;
                    w_sp_nxt = w_sp_dec;
                end
                OP_POP: begin
                    mem_addr = w_sp_inc;
                    w_sp_nxt = w_sp_inc;
                end
                OP_RET: begin
                    mem_addr = w_sp_inc;
                    w_sp_nxt = w_sp_inc;
                    pc_load  = 1'b1;
                end
                OP_INT: begin
                    mem_addr      = r_sp;
                    mem_wdata     = pc_in;
                    mem_we        = 1'b1;
                    w_sp_nxt      = w_sp_dec;
                    stall         = 1'b1;
                    w_state_nxt   = ST_SECOND;
                    w_sec_rti_nxt = 1'b0;
                end
                OP_RTI: begin
                    mem_addr      = w_sp_inc;
                    w_sp_nxt      = w_sp_inc;
                    flags_load    = 1'b1;
                    stall         = 1'b1;
                    w_state_nxt   = ST_SECOND;
                    w_sec_rti_nxt = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .i_clk        (clk),
        .i_rst_n      (rst),
        .i_bubble     (w_bubble),
        .i_sel        (wb_sel_in),
        .i_alu_value  (alu_value_in),
        .i_imm        (imm_in),
        .i_mem_data   (mem_rdata),
        .i_in_port    (in_port_in),
        .i_rd         (rd_in),
        .i_reg_we     (reg_we_in),
        .i_outport_en (outport_en_in),
        .o_sel        (sel),
        .o_alu_value  (alu_value),
        .o_imm        (immediate_value),
        .o_mem_data   (mem_data),
        .o_in_port    (input_port_val),
        .o_rd         (rd),
        .o_reg_we     (reg_we),
        .o_outport_en (outport_enable)
    );

endmodule
